countid_arbiter: RTL and testbench

COUNTID_ARBITER -- requirements
Module: countid_arbiter

---
 rtl/countid_arbiter_pkg.sv | 31 +++
 rtl/countid_arbiter_rr_grant.sv | 56 +++++
 rtl/countid_arbiter.sv | 144 ++++++++++++++
 tb/tb_countid_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countid_arbiter_pkg.sv
// Shared defaults and the in-flight tag record for the countid arbiter.
package countid_arbiter_pkg;

    // Default geometry of the block.
    localparam int unsigned RuleNumDef    = 64;
    localparam int unsigned WidthCountDef = 6;
    localparam int unsigned NumReqDef     = 4;
    localparam int unsigned WidthIdDef    = 2;
    localparam int unsigned PipeLatDef    = 6;

    // The tag id field is sized for the largest supported requester index;
    // narrower WIDTH_ID values are zero-extended into it.
    localparam int unsigned TagIdWidth = 8;

    // Travels alongside a bit vector through the external countid pipeline.
    typedef struct packed {
        logic                  valid;
        logic [TagIdWidth-1:0] id;
        logic                  hit;
    } tag_t;

    function automatic tag_t make_tag(input logic valid, input logic [TagIdWidth-1:0] id,
                                      input logic hit);
        tag_t t;
        t.valid = valid;
        t.id    = id;
        t.hit   = hit;
        return t;
    endfunction

endpackage

// File: rtl/countid_arbiter_rr_grant.sv
// Round-robin grant with a registered search pointer.
module rr_grant #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WIDTH_ID = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  grant,
    output logic                grant_valid,
    output logic [WIDTH_ID-1:0] grant_id
);

    logic [WIDTH_ID-1:0] ptr_q, ptr_d;

    // First valid requester at or above the pointer, wrapping at NUM_REQ.
    always_comb begin
        int unsigned idx;
        grant       = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (enable && !grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_id    = WIDTH_ID'(idx);
            end
        end
        if (grant_valid) begin
            grant[grant_id] = 1'b1;
        end
    end

    // Pointer moves just past the winner; holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_id == WIDTH_ID'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/countid_arbiter.sv
// Arbitrates requesters onto a fixed-latency countid pipeline and re-tags the
// results on their way back.
module countid_arbiter
    import countid_arbiter_pkg::*;
#(
    parameter int unsigned RULE_NUM    = RuleNumDef,
    parameter int unsigned WIDTH_COUNT = WidthCountDef,
    parameter int unsigned NUM_REQ     = NumReqDef,
    parameter int unsigned WIDTH_ID    = WidthIdDef,
    parameter int unsigned PIPE_LAT    = PipeLatDef
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*RULE_NUM-1:0] req_bv,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        pipe_valid,
    output logic [RULE_NUM-1:0]         pipe_bv,
    input  logic                        pipe_countid_valid,
    input  logic [WIDTH_COUNT-1:0]      pipe_countid,
    output logic                        rsp_valid,
    output logic [WIDTH_ID-1:0]         rsp_id,
    output logic [WIDTH_COUNT-1:0]      rsp_countid,
    output logic                        rsp_hit,
    output logic                        busy,
    output logic                        err
);

    logic [NUM_REQ-1:0]     grant;
    logic                   grant_valid;
    logic [WIDTH_ID-1:0]    grant_id;
    logic [RULE_NUM-1:0]    grant_bv;

    tag_t                   issue_tag_q;
    logic [RULE_NUM-1:0]    pipe_bv_q;
    tag_t                   tag_q [PIPE_LAT];
    tag_t                   tail;

    logic                   rsp_valid_q;
    logic [WIDTH_ID-1:0]    rsp_id_q;
    logic [WIDTH_COUNT-1:0] rsp_countid_q;
    logic                   rsp_hit_q;
    logic                   err_q;

    rr_grant #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH_ID (WIDTH_ID)
    ) u_rr_grant (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req_valid   (req_valid),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign req_ready = grant;

    // Select the winner's slice; grant is one-hot so an AND-OR mux suffices.
    always_comb begin
        grant_bv = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_bv = grant_bv | ({RULE_NUM{grant[i]}} & req_bv[i*RULE_NUM +: RULE_NUM]);
        end
    end

    // Issue stage: the tag doubles as the pipe_valid source. An idle tag is
    // all-zero so stray results pick up id 0 and no hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_tag_q <= '0;
            pipe_bv_q   <= '0;
        end else begin
            if (grant_valid) begin
                issue_tag_q <= make_tag(1'b1, TagIdWidth'(grant_id), |grant_bv);
                pipe_bv_q   <= grant_bv;
            end else begin
                issue_tag_q <= '0;
            end
        end
    end

    assign pipe_valid = issue_tag_q.valid;
    assign pipe_bv    = pipe_bv_q;

    // Tag delay line matching the pipeline latency; never stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= issue_tag_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tail = tag_q[PIPE_LAT-1];

    // Response register: the pipeline's own valid wins even when misaligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_countid_q <= '0;
            rsp_hit_q     <= 1'b0;
        end else begin
            rsp_valid_q <= pipe_countid_valid;
            if (pipe_countid_valid) begin
                rsp_id_q      <= WIDTH_ID'(tail.id);
                rsp_hit_q     <= tail.hit;
                rsp_countid_q <= tail.hit ? pipe_countid : '0;
            end
        end
    end

    // Sticky flag for any cycle where result and tag disagree on validity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (pipe_countid_valid != tail.valid) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_countid = rsp_countid_q;
    assign rsp_hit     = rsp_hit_q;
    assign err         = err_q;

    // Anything between grant and response keeps the block busy.
    always_comb begin
        busy = issue_tag_q.valid | rsp_valid_q;
        for (int i = 0; i < PIPE_LAT; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

endmodule

// File: tb/tb_countid_arbiter.sv
module tb_countid_arbiter;

    localparam int RN  = 64;
    localparam int WC  = 6;
    localparam int NR  = 4;
    localparam int WI  = 2;
    localparam int LAT = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [NR-1:0]   req_valid;
    logic [NR*RN-1:0] req_bv;
    logic [NR-1:0]   req_ready;
    logic            pipe_valid;
    logic [RN-1:0]   pipe_bv;
    logic            pipe_countid_valid;
    logic [WC-1:0]   pipe_countid;
    logic            rsp_valid;
    logic [WI-1:0]   rsp_id;
    logic [WC-1:0]   rsp_countid;
    logic            rsp_hit;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    countid_arbiter dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .req_valid          (req_valid),
        .req_bv             (req_bv),
        .req_ready          (req_ready),
        .pipe_valid         (pipe_valid),
        .pipe_bv            (pipe_bv),
        .pipe_countid_valid (pipe_countid_valid),
        .pipe_countid       (pipe_countid),
        .rsp_valid          (rsp_valid),
        .rsp_id             (rsp_id),
        .rsp_countid        (rsp_countid),
        .rsp_hit            (rsp_hit),
        .busy               (busy),
        .err                (err)
    );

    // Expected response: busy from 'from' through 'due', response at 'due'.
    typedef struct {
        int from;
        int due;
        int id;
        bit hit;
        int cid;
    } exp_t;

    typedef struct {
        bit v;
        int cid;
    } pl_t;

    exp_t        expq[$];
    pl_t         line [LAT];
    int          ptr_m;
    bit          exp_pv;
    logic [63:0] exp_pbv;
    int          cyc;
    int          err_cyc;
    bit          inject;
    int          checks;
    int          failures;

    function automatic int low_bit(input logic [63:0] v);
        for (int i = 0; i < 64; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [63:0] rnd_bv();
        logic [63:0] one;
        one = 64'd1;
        case ($urandom_range(3, 0))
            0: return 64'd0;
            1: return one << $urandom_range(63, 0);
            2: return {$urandom, $urandom};
            default: return ({$urandom, $urandom} & {$urandom, $urandom}) << $urandom_range(40, 0);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] bv);
        req_bv[i*RN +: RN] = bv;
    endtask

    task automatic rand_all_bv();
        for (int i = 0; i < NR; i++) set_req(i, rnd_bv());
    endtask

    // One clock: check outputs of the current cycle against the model, then
    // advance and drive the pipeline model for the next cycle.
    task automatic step();
        int          g;
        int          idx;
        logic [3:0]  exp_rdy;
        bit          rv_e;
        bit          busy_e;
        exp_t        hd;
        logic [63:0] bv_g;
        pl_t         d;
        #1;
        g = -1;
        if (enable) begin
            for (int k = 0; k < NR; k++) begin
                idx = (ptr_m + k) % NR;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("pipe_valid", 64'(pipe_valid), 64'(exp_pv));
        chk("pipe_bv", pipe_bv, exp_pbv);

        rv_e   = 1'b0;
        busy_e = 1'b0;
        hd     = '{0, 0, 0, 1'b0, 0};
        foreach (expq[j]) begin
            if (expq[j].due == cyc) begin
                rv_e = 1'b1;
                hd   = expq[j];
            end
            if (expq[j].from <= cyc && cyc <= expq[j].due) busy_e = 1'b1;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(rv_e));
        if (rv_e) begin
            chk("rsp_id", 64'(rsp_id), 64'(hd.id));
            chk("rsp_hit", 64'(rsp_hit), 64'(hd.hit));
            chk("rsp_countid", 64'(rsp_countid), 64'(hd.cid));
        end
        chk("busy", 64'(busy), 64'(busy_e));
        chk("err", 64'(err), 64'(err_cyc >= 0 && cyc > err_cyc));
        for (int j = expq.size() - 1; j >= 0; j--) begin
            if (expq[j].due <= cyc) expq.delete(j);
        end

        bv_g = '0;
        if (g >= 0) begin
            bv_g = req_bv[g*RN +: RN];
            expq.push_back('{cyc + 1, cyc + LAT + 2, g, |bv_g, (|bv_g) ? low_bit(bv_g) : 0});
            ptr_m = (g + 1) % NR;
        end

        @(posedge clk);
        #1;
        cyc++;
        exp_pv = (g >= 0);
        if (g >= 0) exp_pbv = bv_g;

        d = line[LAT-1];
        for (int j = LAT - 1; j > 0; j--) line[j] = line[j-1];
        line[0] = '{pipe_valid, low_bit(pipe_bv)};
        pipe_countid_valid = d.v | inject;
        pipe_countid       = WC'(d.cid);
        if (inject && !d.v) begin
            expq.push_back('{cyc + 1, cyc + 1, 0, 1'b0, 0});
            if (err_cyc < 0) err_cyc = cyc;
        end
        inject = 1'b0;
    endtask

    task automatic do_reset(input int ncyc);
        reset              = 1'b1;
        enable             = 1'b0;
        req_valid          = '0;
        pipe_countid_valid = 1'b0;
        pipe_countid       = '0;
        expq.delete();
        ptr_m   = 0;
        exp_pv  = 1'b0;
        exp_pbv = '0;
        err_cyc = -1;
        inject  = 1'b0;
        for (int j = 0; j < LAT; j++) line[j] = '{1'b0, 0};
        #1;
        chk("rst_pipe_valid", 64'(pipe_valid), 64'd0);
        chk("rst_pipe_bv", pipe_bv, 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_countid", 64'(rsp_countid), 64'd0);
        chk("rst_rsp_hit", 64'(rsp_hit), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        req_bv   = '0;
        do_reset(2);

        // All four held valid: grants rotate 0,1,2,3,0,1,2,3.
        enable    = 1'b1;
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            rand_all_bv();
            step();
        end
        req_valid = '0;
        repeat (10) step();

        // Requester 2 alone with bit 8 set.
        req_valid = 4'b0100;
        set_req(2, 64'h100);
        step();
        req_valid = '0;
        repeat (9) step();

        // Zero bit vector yields no hit and countid 0.
        req_valid = 4'b0010;
        set_req(1, 64'h0);
        step();
        req_valid = '0;
        repeat (9) step();

        // Grants stop with enable low; in-flight work drains.
        req_valid = 4'b1111;
        rand_all_bv();
        step();
        step();
        enable = 1'b0;
        repeat (10) step();
        chk("busy_drained", 64'(busy), 64'd0);

        // Result strobe with nothing outstanding sets sticky err.
        enable    = 1'b1;
        req_valid = '0;
        inject    = 1'b1;
        step();
        repeat (6) step();
        chk("err_sticky", 64'(err), 64'd1);
        do_reset(1);

        // Reset three cycles after an accept discards the request.
        enable    = 1'b1;
        req_valid = 4'b0100;
        set_req(2, 64'h8000);
        step();
        req_valid = '0;
        repeat (3) step();
        do_reset(1);
        enable    = 1'b1;
        req_valid = 4'b1111;
        rand_all_bv();
        step();
        req_valid = '0;
        repeat (12) step();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            enable    = ($urandom_range(7, 0) != 0);
            req_valid = 4'($urandom_range(15, 0));
            rand_all_bv();
            step();
        end
        req_valid = '0;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
